hs_byte_aligner: RTL and testbench

Byte aligner for one MIPI D-PHY RX data lane, sitting directly downstream of the lane's HS-entry detector and the 1:8 deserializer. While the HS-enable from the detector is high, it searches the raw (bit-misaligned) deserialized byte stream for the leader sync byte at any of 8 bit offsets. It then locks that offset for the rest of the burst and emits aligned payload bytes with a valid strobe. It flags bursts in which no sync byte arrives within a bounded time.

---
 rtl/hs_byte_aligner.sv | 154 +++++++++++++++
 tb/tb_hs_byte_aligner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hs_byte_aligner.sv
// hs_byte_aligner: byte aligner for one MIPI D-PHY RX data lane.
//
// Searches the raw deserialized byte stream for the leader sync byte at any
// of 8 bit offsets while the HS window is open. The first (lowest) matching
// offset is locked for the rest of the burst, and the aligned payload bytes
// are emitted with a valid strobe. A burst with no sync byte within
// SYNC_TIMEOUT hunt cycles raises a one-cycle error pulse.
//
// Ports:
//   I_clk       byte clock (single clock domain)
//   I_rst_n     asynchronous active-low reset
//   I_hs_en     HS burst window (registered upstream)
//   I_data      raw deserialized byte, bit 0 received first
//   O_data      aligned payload byte
//   O_valid     O_data holds a payload byte
//   O_sot       one-cycle pulse with the first O_valid of a burst
//   O_offset    locked bit offset; holds until the next lock
//   O_sync_err  one-cycle pulse when the hunt times out
module hs_byte_aligner #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8,
  parameter int unsigned SYNC_TIMEOUT = 32
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_hs_en,
  input  logic [7:0] I_data,
  output logic [7:0] O_data,
  output logic       O_valid,
  output logic       O_sot,
  output logic [2:0] O_offset,
  output logic       O_sync_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HUNT    = 2'd1;
  localparam logic [1:0] S_ALIGNED = 2'd2;
  localparam logic [1:0] S_ERR     = 2'd3;

  localparam logic [7:0] TIMEOUT_LAST = 8'(SYNC_TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  d1_q, d2_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  offset_q, offset_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        sot_q, sot_d;
  logic        first_q, first_d;
  logic        err_pend_q, err_pend_d;
  logic        sync_err_q, sync_err_d;

  logic [15:0] window;
  logic        match_found;
  logic [2:0]  match_k;

  // d2 holds the older byte, so it forms the low half of the window.
  assign window = {d1_q, d2_q};

  // Scan from the highest offset down so the lowest matching offset wins.
  always_comb begin
    match_found = 1'b0;
    match_k     = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (window[(7 - i) +: 8] == SYNC_BYTE) begin
        match_found = 1'b1;
        match_k     = 3'(7 - i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    offset_d   = offset_q;
    first_d    = 1'b0;
    err_pend_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (I_hs_en) state_d = S_HUNT;
      end
      S_HUNT: begin
        if (!I_hs_en) begin
          state_d = S_IDLE;
        end else if (match_found) begin
          state_d  = S_ALIGNED;
          offset_d = match_k;
          first_d  = 1'b1;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d    = S_ERR;
          err_pend_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ALIGNED: begin
        if (!I_hs_en) state_d = S_IDLE;
      end
      S_ERR: begin
        if (!I_hs_en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output register stage; the error pulse is delayed one cycle past the
  // HUNT->ERR transition.
  always_comb begin
    data_d     = data_q;
    valid_d    = 1'b0;
    sot_d      = 1'b0;
    sync_err_d = err_pend_q;
    if (state_q == S_ALIGNED) begin
      data_d  = window[offset_q +: 8];
      valid_d = 1'b1;
      sot_d   = first_q;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q    <= S_IDLE;
      d1_q       <= '0;
      d2_q       <= '0;
      cnt_q      <= '0;
      offset_q   <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sot_q      <= 1'b0;
      first_q    <= 1'b0;
      err_pend_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      d1_q       <= I_data;
      d2_q       <= d1_q;
      cnt_q      <= cnt_d;
      offset_q   <= offset_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sot_q      <= sot_d;
      first_q    <= first_d;
      err_pend_q <= err_pend_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign O_data     = data_q;
  assign O_valid    = valid_q;
  assign O_sot      = sot_q;
  assign O_offset   = offset_q;
  assign O_sync_err = sync_err_q;

endmodule

// File: tb/tb_hs_byte_aligner.sv
// Directed testbench for hs_byte_aligner: k=0 and k=3/k=5 locking, burst
// end, mid-burst reset, hunt timeout and a match coinciding with burst end.
module tb_hs_byte_aligner;

  logic       I_clk = 1'b0;
  logic       I_rst_n = 1'b0;
  logic       I_hs_en = 1'b0;
  logic [7:0] I_data = '0;
  logic [7:0] O_data;
  logic       O_valid;
  logic       O_sot;
  logic [2:0] O_offset;
  logic       O_sync_err;

  int tests = 0;
  int fails = 0;

  hs_byte_aligner #(
    .SYNC_BYTE    (8'hB8),
    .SYNC_TIMEOUT (32)
  ) dut (
    .I_clk      (I_clk),
    .I_rst_n    (I_rst_n),
    .I_hs_en    (I_hs_en),
    .I_data     (I_data),
    .O_data     (O_data),
    .O_valid    (O_valid),
    .O_sot      (O_sot),
    .O_offset   (O_offset),
    .O_sync_err (O_sync_err)
  );

  always #5 I_clk = ~I_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Drive one byte for one cycle; return #1 after the edge, so outputs
  // observed afterwards belong to the following cycle.
  task automatic step(input logic [7:0] d, input logic hs);
    I_data  = d;
    I_hs_en = hs;
    @(posedge I_clk);
    #1;
  endtask

  initial begin
    int first_err;
    int nerr;
    int nvalid;
    int nsot;

    // Reset state
    step(8'h00, 1'b0);
    chk("rst_data", O_data, 8'h00);
    chk("rst_valid", {7'd0, O_valid}, 8'h00);
    chk("rst_sot", {7'd0, O_sot}, 8'h00);
    chk("rst_offset", {5'd0, O_offset}, 8'h00);
    chk("rst_err", {7'd0, O_sync_err}, 8'h00);
    I_rst_n = 1'b1;
    step(8'h00, 1'b0);

    // Aligned sync, k=0: 00,00,B8,11,22,33
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    step(8'hB8, 1'b1);
    chk("k0_pre_valid0", {7'd0, O_valid}, 8'h00);
    step(8'h11, 1'b1);
    step(8'h22, 1'b1);
    chk("k0_pre_valid1", {7'd0, O_valid}, 8'h00);
    step(8'h33, 1'b1);
    chk("k0_b0_data", O_data, 8'h11);
    chk("k0_b0_valid", {7'd0, O_valid}, 8'h01);
    chk("k0_b0_sot", {7'd0, O_sot}, 8'h01);
    chk("k0_offset", {5'd0, O_offset}, 8'h00);
    step(8'h44, 1'b1);
    chk("k0_b1_data", O_data, 8'h22);
    chk("k0_b1_sot", {7'd0, O_sot}, 8'h00);
    step(8'h55, 1'b1);
    chk("k0_b2_data", O_data, 8'h33);
    chk("k0_b2_valid", {7'd0, O_valid}, 8'h01);

    // Burst end: hs_en sampled low now, valid low two cycles later
    step(8'h66, 1'b0);
    chk("end_valid_still", {7'd0, O_valid}, 8'h01);
    step(8'h00, 1'b0);
    chk("end_valid_low", {7'd0, O_valid}, 8'h00);

    // Next burst, sync at k=5: window {17,00}, payload {2A,17}>>5 = 50
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    step(8'h17, 1'b1);
    chk("k5_pre_valid", {7'd0, O_valid}, 8'h00);
    step(8'h2A, 1'b1);
    chk("k5_offset", {5'd0, O_offset}, 8'h05);
    chk("k5_pre_sot", {7'd0, O_sot}, 8'h00);
    step(8'h33, 1'b1);
    chk("k5_b0_data", O_data, 8'h50);
    chk("k5_b0_sot", {7'd0, O_sot}, 8'h01);
    chk("k5_b0_valid", {7'd0, O_valid}, 8'h01);

    // Reset mid-burst (state is ALIGNED here)
    #2;
    I_rst_n = 1'b0;
    #1;
    chk("mrst_data", O_data, 8'h00);
    chk("mrst_valid", {7'd0, O_valid}, 8'h00);
    chk("mrst_sot", {7'd0, O_sot}, 8'h00);
    chk("mrst_offset", {5'd0, O_offset}, 8'h00);
    chk("mrst_err", {7'd0, O_sync_err}, 8'h00);
    step(8'h55, 1'b1);
    I_rst_n = 1'b1;
    step(8'h55, 1'b1);
    step(8'h55, 1'b1);
    step(8'h55, 1'b1);
    step(8'h55, 1'b1);
    chk("mrst_no_relock", {7'd0, O_valid}, 8'h00);
    step(8'hB8, 1'b1);
    step(8'h77, 1'b1);
    step(8'h88, 1'b1);
    chk("mrst_pre_valid", {7'd0, O_valid}, 8'h00);
    step(8'h99, 1'b1);
    chk("mrst_relock_data", O_data, 8'h77);
    chk("mrst_relock_sot", {7'd0, O_sot}, 8'h01);

    // Timeout: HUNT entry at h, sync_err expected at h+33 only
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b1);
    first_err = -1;
    nerr = 0;
    nvalid = 0;
    for (int i = 1; i <= 40; i++) begin
      step(8'h00, 1'b1);
      if (O_sync_err === 1'b1) begin
        nerr++;
        if (first_err < 0) first_err = i;
      end
      if (O_valid !== 1'b0) nvalid++;
    end
    chk("to_err_cycle", 8'(first_err), 8'd33);
    chk("to_err_count", 8'(nerr), 8'd1);
    chk("to_no_valid", 8'(nvalid), 8'd0);

    // Resume HUNT after hs_en drops; sync at k=3 via 00,00,C0,D5,02,AA
    step(8'h00, 1'b0);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    step(8'hC0, 1'b1);
    chk("k3_pre_valid0", {7'd0, O_valid}, 8'h00);
    step(8'hD5, 1'b1);
    chk("k3_pre_valid1", {7'd0, O_valid}, 8'h00);
    step(8'h02, 1'b1);
    chk("k3_offset", {5'd0, O_offset}, 8'h03);
    chk("k3_pre_valid2", {7'd0, O_valid}, 8'h00);
    step(8'hAA, 1'b1);
    chk("k3_b0_data", O_data, 8'h5A);
    chk("k3_b0_sot", {7'd0, O_sot}, 8'h01);
    step(8'h00, 1'b1);
    chk("k3_b1_data", O_data, 8'h40);
    chk("k3_b1_sot", {7'd0, O_sot}, 8'h00);
    chk("k3_b1_valid", {7'd0, O_valid}, 8'h01);

    // Match in the same cycle hs_en is low: no valid, no sot
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b1);
    step(8'hB8, 1'b1);
    step(8'h00, 1'b1);
    step(8'h00, 1'b0);
    nvalid = 0;
    nsot = 0;
    for (int i = 0; i < 5; i++) begin
      if (O_valid !== 1'b0) nvalid++;
      if (O_sot !== 1'b0) nsot++;
      step(8'h00, 1'b0);
    end
    chk("sim_no_valid", 8'(nvalid), 8'd0);
    chk("sim_no_sot", 8'(nsot), 8'd0);
    chk("sim_offset_kept", {5'd0, O_offset}, 8'h03);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
